// File: rtl/flexicore8.sv
// flexicore8: single-cycle 8-bit accumulator CPU with a 7-bit PC and a Harvard program memory.
// The instruction on INSTR executes on every rising edge. r0 maps to IPORT on reads and to OPORT on writes.
module flexicore8 #(
  parameter int PC_LEN    = 7,
  parameter int DATA_LEN  = 8,
  parameter int INSTR_LEN = 8
) (
  input  logic                 CLK,
  input  logic                 RSTN,
  input  logic [DATA_LEN-2:0]  IPORT,
  input  logic [INSTR_LEN-1:0] INSTR,
  output logic [DATA_LEN-2:0]  OPORT,
  output logic [PC_LEN-1:0]    PC
);

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_LD  = 3'd5,
    OP_ST  = 3'd6,
    OP_SHR = 3'd7
  } alu_op_t;

  logic [DATA_LEN-1:0] acc;
  logic [DATA_LEN-1:0] acc_nxt;
  logic [DATA_LEN-1:0] operand;
  logic [DATA_LEN-1:0] rf [1:7];
  logic [PC_LEN-1:0]   pc_nxt;
  logic [DATA_LEN-2:0] oport_nxt;
  logic                rf_we;
  alu_op_t             op;
  logic [2:0]          rsel;

  assign op   = alu_op_t'(INSTR[5:3]);
  assign rsel = INSTR[2:0];

  // r0 reads the input port directly; there is no input register.
  always_comb begin
    operand = {1'b0, IPORT};
    if (rsel != 3'd0) operand = rf[rsel];
  end

  always_comb begin
    pc_nxt    = PC + PC_LEN'(1);
    acc_nxt   = acc;
    oport_nxt = OPORT;
    rf_we     = 1'b0;
    if (INSTR[7]) begin
      if (acc[DATA_LEN-1]) pc_nxt = INSTR[PC_LEN-1:0];
    end else if (INSTR[6]) begin
      acc_nxt = {{(DATA_LEN-6){INSTR[5]}}, INSTR[5:0]};
    end else begin
      case (op)
        OP_ADD: acc_nxt = acc + operand;
        OP_SUB: acc_nxt = acc - operand;
        OP_AND: acc_nxt = acc & operand;
        OP_OR:  acc_nxt = acc | operand;
        OP_XOR: acc_nxt = acc ^ operand;
        OP_LD:  acc_nxt = operand;
        OP_ST: begin
          if (rsel == 3'd0) oport_nxt = acc[DATA_LEN-2:0];
          else              rf_we     = 1'b1;
        end
        OP_SHR: acc_nxt = {1'b0, acc[DATA_LEN-1:1]};
        default: acc_nxt = acc;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      PC    <= '0;
      acc   <= '0;
      OPORT <= '0;
      for (int i = 1; i <= 7; i++) rf[i] <= '0;
    end else begin
      PC    <= pc_nxt;
      acc   <= acc_nxt;
      OPORT <= oport_nxt;
      if (rf_we) rf[rsel] <= acc;
    end
  end

endmodule

// File: tb/tb_flexicore8.sv
// Testbench for flexicore8: directed programs plus random programs checked against an integer-level ISA model.
module tb_flexicore8;

  logic       CLK = 1'b0;
  logic       RSTN = 1'b0;
  logic [6:0] IPORT = '0;
  logic [7:0] INSTR = '0;
  logic [6:0] OPORT;
  logic [6:0] PC;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] prog [128];
  int m_acc, m_pc, m_oport;
  int m_r [8];

  flexicore8 dut (
    .CLK   (CLK),
    .RSTN  (RSTN),
    .IPORT (IPORT),
    .INSTR (INSTR),
    .OPORT (OPORT),
    .PC    (PC)
  );

  always #5 CLK = ~CLK;

  function automatic void model_reset();
    m_acc = 0; m_pc = 0; m_oport = 0;
    for (int i = 0; i < 8; i++) m_r[i] = 0;
  endfunction

  // ISA semantics in plain integer arithmetic, values kept in 0..255
  function automatic void model_exec(input int instr, input int ip);
    int v, r, opnd;
    if (instr >= 128) begin
      if (m_acc >= 128) m_pc = instr - 128;
      else              m_pc = (m_pc + 1) % 128;
      return;
    end
    m_pc = (m_pc + 1) % 128;
    if (instr >= 64) begin
      v = instr - 64;
      if (v >= 32) v = v - 64;
      m_acc = (v + 256) % 256;
      return;
    end
    r = instr % 8;
    opnd = (r == 0) ? ip : m_r[r];
    case (instr / 8)
      0: m_acc = (m_acc + opnd) % 256;
      1: m_acc = (m_acc - opnd + 256) % 256;
      2: m_acc = m_acc & opnd;
      3: m_acc = m_acc | opnd;
      4: m_acc = m_acc ^ opnd;
      5: m_acc = opnd;
      6: if (r == 0) m_oport = m_acc % 128; else m_r[r] = m_acc;
      default: m_acc = m_acc / 2;
    endcase
  endfunction

  task automatic load(input logic [7:0] p[$]);
    for (int i = 0; i < 128; i++) prog[i] = (i < p.size()) ? p[i] : 8'h00;
  endtask

  task automatic apply_reset();
    @(posedge CLK);
    #2 RSTN = 1'b0;
    #2 RSTN = 1'b1;
    model_reset();
  endtask

  task automatic cycle(input bit rand_ip);
    @(negedge CLK);
    if (rand_ip) IPORT = 7'($urandom);
    INSTR = prog[PC];
    model_exec(int'(INSTR), int'(IPORT));
    @(posedge CLK);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0);
  endtask

  task automatic test_reset();
    RSTN = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      INSTR = 8'($urandom);
      IPORT = 7'($urandom);
      @(posedge CLK);
      #1;
    end
    n_tests++;
    if (PC !== 7'd0) begin n_fail++; $display("FAIL reset_pc: got %0h want 0", PC); end
    n_tests++;
    if (OPORT !== 7'd0) begin n_fail++; $display("FAIL reset_oport: got %0h want 0", OPORT); end
    load('{8'h40});
    IPORT = '0;
    RSTN = 1'b1;
    model_reset();
    cycle(1'b0);
    n_tests++;
    if (PC !== 7'd1) begin n_fail++; $display("FAIL reset_first_edge_pc: got %0h want 1", PC); end
  endtask

  task automatic test_imm_output();
    load('{8'h45, 8'h30, 8'h7F, 8'h83});
    apply_reset();
    run(2);
    n_tests++;
    if (OPORT !== 7'h05) begin n_fail++; $display("FAIL imm_oport: got %0h want 05", OPORT); end
    run(6);
    n_tests++;
    if (PC !== 7'd3) begin n_fail++; $display("FAIL imm_halt_pc: got %0h want 3", PC); end
    n_tests++;
    if (OPORT !== 7'(m_oport)) begin n_fail++; $display("FAIL imm_model_oport: got %0h want %0h", OPORT, m_oport); end
  endtask

  task automatic test_arith();
    load('{8'h54, 8'h31, 8'h56, 8'h01, 8'h30, 8'h7F, 8'h86});
    apply_reset();
    run(10);
    n_tests++;
    if (OPORT !== 7'h2A) begin n_fail++; $display("FAIL arith_add: got %0h want 2a", OPORT); end
    n_tests++;
    if (PC !== 7'd6) begin n_fail++; $display("FAIL arith_add_halt: got %0h want 6", PC); end
    load('{8'h54, 8'h31, 8'h56, 8'h09, 8'h30, 8'h7F, 8'h86});
    apply_reset();
    run(10);
    n_tests++;
    if (OPORT !== 7'h02) begin n_fail++; $display("FAIL arith_sub: got %0h want 02", OPORT); end
    // 0 - 20 = 0xEC: negative, so the BRN to self at 5 is taken directly
    load('{8'h54, 8'h31, 8'h40, 8'h09, 8'h30, 8'h85});
    apply_reset();
    run(9);
    n_tests++;
    if (OPORT !== 7'h6C) begin n_fail++; $display("FAIL arith_sub_neg: got %0h want 6c", OPORT); end
    n_tests++;
    if (PC !== 7'd5) begin n_fail++; $display("FAIL arith_neg_halt: got %0h want 5", PC); end
  endtask

  task automatic test_input_port();
    IPORT = 7'h55;
    load('{8'h7F, 8'h38, 8'h32, 8'h28, 8'h22, 8'h30, 8'h38, 8'h30, 8'h7F, 8'h89});
    apply_reset();
    run(6);
    n_tests++;
    if (OPORT !== 7'h2A) begin n_fail++; $display("FAIL input_xor: got %0h want 2a", OPORT); end
    run(2);
    n_tests++;
    if (OPORT !== 7'h15) begin n_fail++; $display("FAIL input_shr: got %0h want 15", OPORT); end
    run(4);
    n_tests++;
    if (PC !== 7'd9) begin n_fail++; $display("FAIL input_halt: got %0h want 9", PC); end
    IPORT = '0;
  endtask

  task automatic test_branch();
    load('{8'h50, 8'hD0, 8'h60, 8'h33, 8'h03, 8'h03, 8'h34, 8'h60, 8'h04, 8'hD0});
    prog[7'h50] = 8'hD0;
    apply_reset();
    run(2);
    n_tests++;
    if (PC !== 7'd2) begin n_fail++; $display("FAIL branch_not_taken: got %0h want 2", PC); end
    run(8);
    n_tests++;
    if (PC !== 7'h50) begin n_fail++; $display("FAIL branch_taken: got %0h want 50", PC); end
    run(3);
    n_tests++;
    if (PC !== 7'h50) begin n_fail++; $display("FAIL branch_halt_hold: got %0h want 50", PC); end
  endtask

  task automatic test_wrap();
    load('{});
    IPORT = '0;
    apply_reset();
    run(127);
    n_tests++;
    if (PC !== 7'd127) begin n_fail++; $display("FAIL wrap_pc127: got %0h want 7f", PC); end
    run(1);
    n_tests++;
    if (PC !== 7'd0) begin n_fail++; $display("FAIL wrap_pc0: got %0h want 0", PC); end
  endtask

  task automatic test_async_reset();
    load('{8'h54, 8'h31, 8'h56, 8'h01, 8'h30, 8'h7F, 8'h86});
    apply_reset();
    run(10);
    n_tests++;
    if (OPORT !== 7'h2A) begin n_fail++; $display("FAIL async_pre: got %0h want 2a", OPORT); end
    @(negedge CLK);
    #2 RSTN = 1'b0;
    #1;
    n_tests++;
    if (PC !== 7'd0) begin n_fail++; $display("FAIL async_pc_clear: got %0h want 0", PC); end
    n_tests++;
    if (OPORT !== 7'd0) begin n_fail++; $display("FAIL async_oport_clear: got %0h want 0", OPORT); end
    @(posedge CLK);
    #1 RSTN = 1'b1;
    model_reset();
    run(1);
    n_tests++;
    if (PC !== 7'd1 || OPORT !== 7'd0) begin
      n_fail++; $display("FAIL async_restart: got pc %0h oport %0h want pc 1 oport 0", PC, OPORT);
    end
    run(4);
    n_tests++;
    if (OPORT !== 7'h2A) begin n_fail++; $display("FAIL async_rerun: got %0h want 2a", OPORT); end
  endtask

  task automatic test_random();
    for (int s = 0; s < 6; s++) begin
      for (int i = 0; i < 128; i++) prog[i] = 8'($urandom);
      apply_reset();
      for (int c = 0; c < 150; c++) begin
        cycle(1'b1);
        n_tests++;
        if (PC !== 7'(m_pc) || OPORT !== 7'(m_oport)) begin
          n_fail++;
          $display("FAIL random_s%0d_c%0d: got pc %0h oport %0h want pc %0h oport %0h",
                   s, c, PC, OPORT, m_pc, m_oport);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_imm_output();
    test_arith();
    test_input_port();
    test_branch();
    test_wrap();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
